// File: rtl/ffnn_scheduler.sv
// Shares one FeedForwardNN between NREQ requesters, one transaction in flight.
// Define FFNN_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ffnn_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 9,
    parameter int LAT  = 1,
    parameter int IDW  = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*4*W-1:0]      req_data,
    output logic signed [W-1:0]      nn_x0,
    output logic signed [W-1:0]      nn_x1,
    output logic signed [W-1:0]      nn_x2,
    output logic signed [W-1:0]      nn_x3,
    input  logic                     nn_y0,
    input  logic                     nn_y1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_y0,
    output logic                     rsp_y1
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   start_s;
    logic [PW-1:0]   grant_s;
    logic [PW-1:0]   ptr_next_s;
    logic            found_s;
    logic            hit_s;
    logic            accept_s;
    logic [4*W-1:0]  sel_s;

`ifdef FFNN_SCHED_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    always_comb begin
        start_s = '0;
    end
`else
    logic [PW-1:0]   ptr_r;

    // Round-robin: the search starts at the pointer.
    always_comb begin
        start_s = ptr_r;
    end
`endif

    // Two-pass search: indices at/above start first, then the wrapped-around ones.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            hit_s   = !found_s && req_valid[i] && (PW'(i) >= start_s);
            grant_s = hit_s ? PW'(i) : grant_s;
            found_s = found_s | hit_s;
        end
        for (int i = 0; i < NREQ; i++) begin
            hit_s   = !found_s && req_valid[i] && (PW'(i) < start_s);
            grant_s = hit_s ? PW'(i) : grant_s;
            found_s = found_s | hit_s;
        end
    end

    // Mux the granted requester's vector.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_s = (grant_s == PW'(i)) ? req_data[i*4*W +: 4*W] : sel_s;
        end
    end

    // Pointer successor, wrapping at NREQ-1.
    always_comb begin
        ptr_next_s = (grant_s == PW'(NREQ - 1)) ? '0 : grant_s + 1'b1;
    end

    // Grant is combinational and only in IDLE outside reset.
    always_comb begin
        accept_s  = !RST && (state_r == S_IDLE) && found_s;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept_s && (grant_s == PW'(i));
        end
    end

    // Transaction FSM with registered network drive and response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
`ifndef FFNN_SCHED_FIXED_PRIO_EN
            ptr_r     <= '0;
`endif
            nn_x0     <= '0;
            nn_x1     <= '0;
            nn_x2     <= '0;
            nn_x3     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y0    <= 1'b0;
            rsp_y1    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (found_s) begin
                        nn_x0   <= sel_s[0*W +: W];
                        nn_x1   <= sel_s[1*W +: W];
                        nn_x2   <= sel_s[2*W +: W];
                        nn_x3   <= sel_s[3*W +: W];
                        rsp_id  <= IDW'(grant_s);
                        cnt_r   <= CW'(LAT);
`ifndef FFNN_SCHED_FIXED_PRIO_EN
                        ptr_r   <= ptr_next_s;
`endif
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_r == '0) begin
                        rsp_y0    <= nn_y0;
                        rsp_y1    <= nn_y1;
                        rsp_valid <= 1'b1;
                        state_r   <= S_RESP;
                    end else begin
                        cnt_r     <= cnt_r - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r   <= S_RESP;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffnn_scheduler.sv
// Directed self-checking bench: LAT=1 instance for function, LAT=3 instance for timing.
module tb_ffnn_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready;
    logic [143:0] req_data;
    logic signed [8:0] nn_x0, nn_x1, nn_x2, nn_x3;
    logic         nn_y0, nn_y1, rsp_valid, rsp_ready, rsp_y0, rsp_y1;
    logic [2:0]   rsp_id;

    logic [3:0]   b_req_valid, b_req_ready;
    logic [143:0] b_req_data;
    logic signed [8:0] b_nn_x0, b_nn_x1, b_nn_x2, b_nn_x3;
    logic         b_nn_y0, b_nn_y1, b_rsp_valid, b_rsp_ready, b_rsp_y0, b_rsp_y1;
    logic [2:0]   b_rsp_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ffnn_scheduler #(.NREQ(4), .W(9), .LAT(1), .IDW(3)) dut_a (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .nn_x0(nn_x0), .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_x3(nn_x3),
        .nn_y0(nn_y0), .nn_y1(nn_y1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y0(rsp_y0), .rsp_y1(rsp_y1)
    );

    ffnn_scheduler #(.NREQ(4), .W(9), .LAT(3), .IDW(3)) dut_b (
        .CLK(clk), .RST(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
        .nn_x0(b_nn_x0), .nn_x1(b_nn_x1), .nn_x2(b_nn_x2), .nn_x3(b_nn_x3),
        .nn_y0(b_nn_y0), .nn_y1(b_nn_y1), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_y0(b_rsp_y0), .rsp_y1(b_rsp_y1)
    );

    // Requester r offers x_j = 16*r + j + 1.
    function automatic logic [35:0] vec(input int r);
        return {9'(16*r + 4), 9'(16*r + 3), 9'(16*r + 2), 9'(16*r + 1)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        checks++;
        if ({nn_x0, nn_x1, nn_x2, nn_x3} !== 36'd0) begin
            errors++;
            $display("FAIL reset_nn_x: got %h expected 0", {nn_x0, nn_x1, nn_x2, nn_x3});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_y0, rsp_y1, b_rsp_valid} !== 7'd0) begin
            errors++;
            $display("FAIL reset_rsp: got %b expected 0000000", {rsp_valid, rsp_id, rsp_y0, rsp_y1, b_rsp_valid});
        end
    endtask

    task automatic test_single;
        rsp_ready = 1'b0;
        req_data = '0;
        req_data[35:0] = {9'd149, 9'd106, 9'd243, 9'd196};
        req_valid = 4'b0001;
        nn_y0 = 1'b0;
        nn_y1 = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if ({nn_x3, nn_x2, nn_x1, nn_x0} !== {9'd149, 9'd106, 9'd243, 9'd196}) begin
            errors++;
            $display("FAIL single_nn_x: got %0d %0d %0d %0d expected 196 243 106 149",
                     $unsigned(nn_x0), $unsigned(nn_x1), $unsigned(nn_x2), $unsigned(nn_x3));
        end
        checks++;
        if ({rsp_valid, req_ready} !== 5'b0_0000) begin
            errors++;
            $display("FAIL single_wait: got valid=%b ready=%b expected 0 0000", rsp_valid, req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got %b expected 0", rsp_valid);
        end
        nn_y0 = 1'b1;
        nn_y1 = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_y0, rsp_y1} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%0d y=%b%b expected v=1 id=0 y=10",
                     rsp_valid, rsp_id, rsp_y0, rsp_y1);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got %b expected 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_contention;
        int exp_g;
        logic [3:0] exp_rdy;
        do_reset();
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) req_data[r*36 +: 36] = vec(r);
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
`ifdef FFNN_SCHED_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = t % 4;
`endif
            exp_rdy = 4'b0001 << exp_g;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b expected %b", t, req_ready, exp_rdy);
            end
            tick();
            checks++;
            if ({nn_x3, nn_x2, nn_x1, nn_x0} !== vec(exp_g) || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL contention_data[%0d]: got x0=%0d ready=%b expected x0=%0d ready=0000",
                         t, $unsigned(nn_x0), req_ready, 16*exp_g + 1);
            end
            tick();
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 3'(exp_g)) begin
                errors++;
                $display("FAIL contention_rsp[%0d]: got v=%b id=%0d expected v=1 id=%0d",
                         t, rsp_valid, rsp_id, exp_g);
            end
            tick();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        nn_y0 = 1'b1;
        nn_y1 = 1'b1;
        tick();
        tick();
        nn_y0 = 1'b0;
        nn_y1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_y0, rsp_y1, req_ready} !== {1'b1, 3'd1, 1'b1, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d y=%b%b ready=%b expected v=1 id=1 y=11 ready=0000",
                         c, rsp_valid, rsp_id, rsp_y0, rsp_y1, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000 || nn_x0 !== 9'd17) begin
            errors++;
            $display("FAIL bp_release: got v=%b ready=%b x0=%0d expected v=0 ready=1000 x0=17",
                     rsp_valid, req_ready, $unsigned(nn_x0));
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (nn_x0 !== 9'd49 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_next_accept: got x0=%0d ready=%b expected x0=49 ready=0000",
                     $unsigned(nn_x0), req_ready);
        end
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_y0} !== {1'b1, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL bp_next_rsp: got v=%b id=%0d y0=%b expected v=1 id=3 y0=0", rsp_valid, rsp_id, rsp_y0);
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rstw_grant: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        nn_y0 = 1'b1;
        nn_y1 = 1'b1;
        checks++;
        if (nn_x0 !== 9'd33) begin
            errors++;
            $display("FAIL rstw_accept: got x0=%0d expected 33", $unsigned(nn_x0));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({nn_x0, nn_x1, nn_x2, nn_x3, rsp_valid, rsp_id, rsp_y0, rsp_y1} !== 42'd0) begin
            errors++;
            $display("FAIL rstw_outputs: got %h expected 0",
                     {nn_x0, nn_x1, nn_x2, nn_x3, rsp_valid, rsp_id, rsp_y0, rsp_y1});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstw_no_rsp[%0d]: got %b expected 0", c, rsp_valid);
            end
        end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstw_ptr: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_latency;
        int t;
        int rise;
        int period;
        logic [2:0] rid;
        logic ry0;
        b_rsp_ready = 1'b1;
        b_nn_y0 = 1'b1;
        b_nn_y1 = 1'b0;
        b_req_data = '0;
        b_req_data[2*36 +: 36] = vec(2);
        b_req_valid = 4'b0100;
        #1;
        checks++;
        if (b_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL lat_grant: got %b expected 0100", b_req_ready);
        end
        tick();
        checks++;
        if ({b_nn_x3, b_nn_x2, b_nn_x1, b_nn_x0} !== vec(2)) begin
            errors++;
            $display("FAIL lat_data: got %h expected %h", {b_nn_x3, b_nn_x2, b_nn_x1, b_nn_x0}, vec(2));
        end
        t = 0;
        rise = -1;
        period = -1;
        rid = 3'd0;
        ry0 = 1'b0;
        while (t < 20 && period < 0) begin
            tick();
            t++;
            if (rise < 0 && b_rsp_valid === 1'b1) begin
                rise = t;
                rid = b_rsp_id;
                ry0 = b_rsp_y0;
            end
            if (b_req_ready === 4'b0100) period = t + 1;
        end
        b_req_valid = 4'b0000;
        checks++;
        if (rise !== 4 || rid !== 3'd2 || ry0 !== 1'b1) begin
            errors++;
            $display("FAIL lat_rise: got cycles=%0d id=%0d y0=%b expected cycles=4 id=2 y0=1", rise, rid, ry0);
        end
        checks++;
        if (period !== 6) begin
            errors++;
            $display("FAIL lat_throughput: got %0d cycles expected 6", period);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = '0;
        nn_y0 = 1'b0;
        nn_y1 = 1'b0;
        rsp_ready = 1'b0;
        b_req_valid = 4'b0000;
        b_req_data = '0;
        b_nn_y0 = 1'b0;
        b_nn_y1 = 1'b0;
        b_rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid_wait();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ffnn_scheduler.md
# ffnn_scheduler

Arbitrates a single shared FeedForwardNN instance between NREQ requesters. Each requester offers a 4-element input vector (x0..x3); the scheduler grants one requester at a time, drives the vector onto the network inputs, and waits out the network's fixed latency. It then captures y0/y1 and returns them with the requester index over a valid/ready response channel. Sits between the feature sources and the FeedForwardNN datapath, one transaction in flight.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 9: signed width of each x element, matching the FeedForwardNN inputs.
- LAT, 1: FeedForwardNN cycles from stable x inputs to valid y outputs, ≥1.
- IDW, 3: width of rsp_id, ≥ clog2(NREQ).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, synchronous and active-high.
- req_valid  in  NREQ  per-requester vector offer.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_data  in  NREQ*4*W  requester i at bits [i*4W +: 4W], x0 in the LSBs, x3 in the MSBs.
- nn_x0..nn_x3  out  W each  registered drive to FeedForwardNN x0..x3 (signed).
- nn_y0, nn_y1  in  1 each  FeedForwardNN outputs.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_y0, rsp_y1  out  1 each  captured network outputs.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, pick grant g and assert req_ready[g] combinationally in the same cycle.
  - At that edge (accept edge k): latch the req_data slice of g into nn_x0..3 and g into rsp_id; load cnt=LAT; go to WAIT.
- WAIT:
  - cnt decrements each edge.
  - At the edge where cnt==0: register nn_y0/nn_y1 into rsp_y0/rsp_y1; set rsp_valid; go to RESP.
- RESP:
  - Hold rsp_* stable until rsp_valid && rsp_ready at an edge.
  - At that edge: clear rsp_valid; go to IDLE.
- req_ready is all-zero outside IDLE. Requesters must hold req_valid and req_data until accepted.
- Arbitration is round-robin with pointer ptr:
  - The search starts at ptr and wraps mod NREQ.
  - On accept, ptr ← (g+1) mod NREQ.
- nn_x0..3 hold the last accepted vector until the next accept. They are never modified during WAIT/RESP.
- Data is passed through unmodified: no sign extension or truncation of x elements.
- Requester index g never exceeds NREQ-1. Unused rsp_id MSBs are zero.

## Timing
- Reset:
  - state=IDLE, ptr=0, cnt=0.
  - nn_x0..3=0, rsp_valid=0, rsp_id=0, rsp_y0=0, rsp_y1=0.
  - req_ready=0 during the reset cycle.
- Accept at edge k:
  - nn_x visible after k.
  - y captured at edge k+LAT+1.
  - rsp_valid high from k+LAT+1.
- rsp_ready already high when rsp_valid rises: RESP lasts exactly 1 cycle, and the next accept can occur at edge k+LAT+3.
- Back-to-back throughput with rsp_ready tied high: one transaction per LAT+3 cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others keep waiting with req_ready=0.
- req_valid dropping while in IDLE without being accepted is legal; no grant occurs for that requester.
- RST mid-transaction (WAIT or RESP):
  - The transaction is dropped and no response is produced.
  - All state returns to reset values at that edge.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Configuration
- FFNN_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest asserted requester index always wins; ptr is not implemented.
  - Undefined (default): round-robin as described in Operation.
- All timing is identical in both modes.

## Test plan
- Single request, LAT=1: req_valid[0]=1, vector (x0..x3)=(196,243,106,149).
  - req_ready[0] is high in the IDLE cycle.
  - nn_x0..3 equal 196, 243, 106, 149 after the accept edge.
  - rsp_valid rises 2 cycles after accept with rsp_id=0, and y equals the network's y sampled at that edge.
- Contention: req_valid=4'b1111, rsp_ready=1, all requesters held.
  - Grants occur in order 0,1,2,3,0.
  - With FFNN_SCHED_FIXED_PRIO_EN, requester 0 is granted every time.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_id/rsp_y stay stable; req_ready stays 0; no new accept.
  - Raise rsp_ready: accept on that edge, then IDLE on the next cycle.
- Reset mid-WAIT: assert RST for 1 cycle during WAIT.
  - No rsp_valid follows; all outputs are 0.
  - ptr=0, so requester 0 wins the next arbitration.
- Latency sweep at LAT=3, request at idx 2 only: rsp_valid rises exactly 4 cycles after accept with rsp_id=2; a throughput of one transaction per 6 cycles is measured.
